pb_debounce_multi: RTL and testbench



---
 rtl/pb_debounce_multi.sv | 120 ++++++++++++
 tb/tb_pb_debounce_multi.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce_multi
// Description : Multi-channel pushbutton conditioner. Each channel has a
//               synchroniser, a stability-counter debouncer, registered
//               rise/fall pulses on debounced transitions and an optional
//               auto-repeat pulse train while the button is held.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_multi #(
  parameter int   N_CH          = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   DB_CYCLES     = 50000,
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter int   HOLD_CYCLES   = 25000000,
  parameter int   REPEAT_CYCLES = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt
);

  localparam int CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int H_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int H_W    = $clog2(H_MAX + 1);
  // A repeat period longer than the hold time cannot be expressed as a
  // reload offset, so the counter restarts from zero in that case.
  localparam int RELOAD = (REPEAT_CYCLES >= HOLD_CYCLES) ? 0 : (HOLD_CYCLES - REPEAT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [H_W-1:0]   HOLD_V   = H_W'(HOLD_CYCLES);
  localparam logic [H_W-1:0]   RELOAD_V = H_W'(RELOAD);
  localparam logic             RPT_EN   = (HOLD_CYCLES != 0);

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic [H_W-1:0]         r_hold;
      logic                   r_level;
      logic                   r_rise;
      logic                   r_fall;
      logic                   r_rpt;
      logic                   w_s;
      logic                   w_accept;
      logic                   w_held;
      logic [H_W-1:0]         w_hold_nxt;

      assign w_s        = r_sync[SYNC_STAGES-1];
      // A new level is taken on this edge once s has differed long enough.
      assign w_accept   = (w_s != r_level) && (r_cnt == CNT_LAST);
      // Holding excludes the release edge so no repeat lands on it.
      assign w_held     = RPT_EN && (r_level == ~IDLE_LEVEL) && !w_accept;
      assign w_hold_nxt = r_hold + 1'b1;

      // Synchroniser chain for the raw button line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], pb[i]};
        end
      end

      // Stability counter: accept a new level after DB_CYCLES differing samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_level <= IDLE_LEVEL;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (w_s == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_level <= w_s;
            r_cnt   <= '0;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // Hold counter: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold <= '0;
          r_rpt  <= 1'b0;
        end else if (w_held) begin
          if (w_hold_nxt == HOLD_V) begin
            r_rpt  <= 1'b1;
            r_hold <= RELOAD_V;
          end else begin
            r_rpt  <= 1'b0;
            r_hold <= w_hold_nxt;
          end
        end else begin
          r_hold <= '0;
          r_rpt  <= 1'b0;
        end
      end

      assign level[i] = r_level;
      assign rise[i]  = r_rise;
      assign fall[i]  = r_fall;
      assign rpt[i]   = r_rpt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_debounce_multi
// Description : Directed self-checking bench for pb_debounce_multi with
//               N_CH=2, SYNC_STAGES=2, DB_CYCLES=4, HOLD=8, REPEAT=3.
//               Observed vector is {level, rise, fall, rpt} (8 bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_debounce_multi;

  localparam int   N_CH          = 2;
  localparam int   SYNC_STAGES   = 2;
  localparam int   DB_CYCLES     = 4;
  localparam logic IDLE_LEVEL    = 1'b1;
  localparam int   HOLD_CYCLES   = 8;
  localparam int   REPEAT_CYCLES = 3;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] pb    = 2'b00;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] rpt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pb_debounce_multi #(
    .N_CH          (N_CH),
    .SYNC_STAGES   (SYNC_STAGES),
    .DB_CYCLES     (DB_CYCLES),
    .IDLE_LEVEL    (IDLE_LEVEL),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .rpt   (rpt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] lv;
    logic [1:0] r;
    logic [1:0] f;
    logic [1:0] p;

    // Reset held with both buttons pressed.
    rst_n = 1'b0;
    pb    = 2'b00;
    repeat (3) tick();
    check("reset", {24'b0, level, rise, fall, rpt}, {24'b0, 2'b11, 6'b0});

    // Release reset with both pressed: both fall at edge 6, then release both.
    rst_n = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      lv = (t >= 6 && t < 12) ? 2'b00 : 2'b11;
      f  = (t == 6)  ? 2'b11 : 2'b00;
      r  = (t == 12) ? 2'b11 : 2'b00;
      p  = 2'b00;
      check($sformatf("rst_rel t=%0d", t), {24'b0, level, rise, fall, rpt}, {24'b0, lv, r, f, p});
      if (t == 6) pb = 2'b11;
    end

    // Clean press on ch0 held 20 cycles: repeats at +8,+11,+14,+17,
    // release lands on +20 where a repeat would otherwise fire.
    pb = 2'b10;
    for (int t = 1; t <= 28; t++) begin
      tick();
      lv = {1'b1, ~(t >= 6 && t < 26)};
      f  = {1'b0, (t == 6)};
      r  = {1'b0, (t == 26)};
      p  = {1'b0, (t == 14 || t == 17 || t == 20 || t == 23)};
      check($sformatf("press_rpt t=%0d", t), {24'b0, level, rise, fall, rpt}, {24'b0, lv, r, f, p});
      if (t == 20) pb = 2'b11;
    end

    // Bounce on ch0: 0 for 3, 1 for 3, then 0; single fall at 12, release -> rise at 18.
    pb = 2'b10;
    for (int t = 1; t <= 20; t++) begin
      tick();
      lv = {1'b1, ~(t >= 12 && t < 18)};
      f  = {1'b0, (t == 12)};
      r  = {1'b0, (t == 18)};
      p  = 2'b00;
      check($sformatf("bounce t=%0d", t), {24'b0, level, rise, fall, rpt}, {24'b0, lv, r, f, p});
      if (t == 3)  pb = 2'b11;
      if (t == 6)  pb = 2'b10;
      if (t == 12) pb = 2'b11;
    end

    // Glitch on ch1 one cycle shorter than the debounce window.
    pb = 2'b01;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check($sformatf("glitch t=%0d", t), {24'b0, level, rise, fall, rpt}, {24'b0, 2'b11, 6'b0});
      if (t == 3) pb = 2'b11;
    end

    // Press ch0, then async reset at +10 after the press pulse.
    pb = 2'b10;
    for (int t = 1; t <= 16; t++) begin
      tick();
      lv = {1'b1, ~(t >= 6)};
      f  = {1'b0, (t == 6)};
      r  = 2'b00;
      p  = {1'b0, (t == 14)};
      check($sformatf("hold t=%0d", t), {24'b0, level, rise, fall, rpt}, {24'b0, lv, r, f, p});
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {24'b0, level, rise, fall, rpt}, {24'b0, 2'b11, 6'b0});
    repeat (2) tick();

    // Release reset with ch0 still pressed: debounces to a normal press pulse.
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      lv = {1'b1, ~(t >= 6)};
      f  = {1'b0, (t == 6)};
      check($sformatf("post_rst t=%0d", t), {24'b0, level, rise, fall, rpt}, {24'b0, lv, 2'b00, f, 2'b00});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
